// File: rtl/pingpong_stream_scheduler.sv
// ---------------------------------------------------------------------------
// pingpong_stream_scheduler
//
// Splits one AXI-Stream input into two outputs in ping-pong fashion. Groups
// of cfg_pp_group packets (cfg_packet_size beats each) go alternately to
// out1 and out2. Each path frames its own packet sequence independently and
// raises tlast on the last beat of every cfg_frame_pkts-th packet. Routing
// is combinational. Counters advance only on accepted input beats, so
// backpressure from the selected output stalls the whole chain.
//
// Ports
//   clk, resetn           clock, synchronous active-low reset
//   cfg_packet_size       beats per packet           (latched on start)
//   cfg_pp_group          packets per ping-pong group (latched on start)
//   cfg_frame_pkts        packets per frame per path  (latched on start)
//   start / stop          single-cycle control pulses
//   busy                  high while RUN or DRAIN
//   cfg_err               sticky; set when start sees a zero config field
//   cur_path              0 = out1 selected, 1 = out2 selected
//   frames_out1/2         completed frames (accepted tlast beats) per path
//   axis_in_*             input stream
//   axis_out1_*/out2_*    output streams
// ---------------------------------------------------------------------------
module pingpong_stream_scheduler #(
  parameter int DW = 128,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [CW-1:0] cfg_packet_size,
  input  logic [CW-1:0] cfg_pp_group,
  input  logic [CW-1:0] cfg_frame_pkts,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          cfg_err,
  output logic          cur_path,
  output logic [CW-1:0] frames_out1,
  output logic [CW-1:0] frames_out2,
  input  logic [DW-1:0] axis_in_tdata,
  input  logic          axis_in_tvalid,
  output logic          axis_in_tready,
  output logic [DW-1:0] axis_out1_tdata,
  output logic          axis_out1_tvalid,
  output logic          axis_out1_tlast,
  input  logic          axis_out1_tready,
  output logic [DW-1:0] axis_out2_tdata,
  output logic          axis_out2_tvalid,
  output logic          axis_out2_tlast,
  input  logic          axis_out2_tready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] pkt_size_q, pp_group_q, frame_pkts_q;
  logic [CW-1:0] beat_cnt, grp_cnt, frm_cnt1, frm_cnt2;

  logic cfg_zero;
  logic pkt_last;   // current beat ends a packet
  logic grp_last;   // current packet ends the group
  logic frm_last;   // current packet ends a frame on the selected path
  logic acc;        // input beat accepted this cycle
  logic sel_tlast;

  assign cfg_zero = (cfg_packet_size == '0) || (cfg_pp_group == '0) ||
                    (cfg_frame_pkts == '0);
  assign pkt_last = (beat_cnt == pkt_size_q - CNT_ONE);
  assign grp_last = (grp_cnt == pp_group_q - CNT_ONE);
  assign frm_last = ((cur_path ? frm_cnt2 : frm_cnt1) == frame_pkts_q - CNT_ONE);

  // ---------------------------------------------------------------------
  // Combinational routing
  // ---------------------------------------------------------------------
  assign busy           = (state_q != S_IDLE);
  assign axis_in_tready = busy & (cur_path ? axis_out2_tready : axis_out1_tready);
  assign acc            = axis_in_tvalid & axis_in_tready;
  assign sel_tlast      = busy & axis_in_tvalid & pkt_last & frm_last;

  assign axis_out1_tdata  = cur_path ? '0 : axis_in_tdata;
  assign axis_out1_tvalid = ~cur_path & axis_in_tvalid & busy;
  assign axis_out1_tlast  = ~cur_path & sel_tlast;
  assign axis_out2_tdata  = cur_path ? axis_in_tdata : '0;
  assign axis_out2_tvalid = cur_path & axis_in_tvalid & busy;
  assign axis_out2_tlast  = cur_path & sel_tlast;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of process ordering.
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first; any path that skips an assignment
    // would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && !cfg_zero) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          // Already on a group boundary, or the group's final beat is being
          // accepted right now: nothing left to finish.
          if ((beat_cnt == '0 && grp_cnt == '0) || (acc && pkt_last && grp_last))
            state_d = S_IDLE;
          else
            state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (acc && pkt_last && grp_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Config latch, counters, status
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pkt_size_q   <= '0;
      pp_group_q   <= '0;
      frame_pkts_q <= '0;
      beat_cnt     <= '0;
      grp_cnt      <= '0;
      frm_cnt1     <= '0;
      frm_cnt2     <= '0;
      cur_path     <= 1'b0;
      cfg_err      <= 1'b0;
      frames_out1  <= '0;
      frames_out2  <= '0;
    end else if (state_q == S_IDLE && start) begin
      if (cfg_zero) begin
        cfg_err <= 1'b1;
      end else begin
        pkt_size_q   <= cfg_packet_size;
        pp_group_q   <= cfg_pp_group;
        frame_pkts_q <= cfg_frame_pkts;
        beat_cnt     <= '0;
        grp_cnt      <= '0;
        frm_cnt1     <= '0;
        frm_cnt2     <= '0;
        cur_path     <= 1'b0;
        cfg_err      <= 1'b0;
      end
    end else if (acc) begin
      if (!pkt_last) begin
        beat_cnt <= beat_cnt + CNT_ONE;
      end else begin
        beat_cnt <= '0;
        grp_cnt  <= grp_last ? '0 : grp_cnt + CNT_ONE;
        if (grp_last) cur_path <= ~cur_path;
        // Only the active path's frame counter moves; the idle path keeps
        // its partial frame across groups.
        if (!cur_path) begin
          frm_cnt1 <= frm_last ? '0 : frm_cnt1 + CNT_ONE;
          if (frm_last) frames_out1 <= frames_out1 + CNT_ONE;
        end else begin
          frm_cnt2 <= frm_last ? '0 : frm_cnt2 + CNT_ONE;
          if (frm_last) frames_out2 <= frames_out2 + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pingpong_stream_scheduler.sv
// ---------------------------------------------------------------------------
// Directed testbench for pingpong_stream_scheduler. Inputs change 1 ns after
// the rising edge; outputs are compared 3 ns after the edge.
// ---------------------------------------------------------------------------
module tb_pingpong_stream_scheduler;

  localparam int DW = 128;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic [CW-1:0] cfg_packet_size, cfg_pp_group, cfg_frame_pkts;
  logic          start, stop;
  logic          busy, cfg_err, cur_path;
  logic [CW-1:0] frames_out1, frames_out2;
  logic [DW-1:0] axis_in_tdata;
  logic          axis_in_tvalid, axis_in_tready;
  logic [DW-1:0] axis_out1_tdata, axis_out2_tdata;
  logic          axis_out1_tvalid, axis_out1_tlast, axis_out1_tready;
  logic          axis_out2_tvalid, axis_out2_tlast, axis_out2_tready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pingpong_stream_scheduler #(.DW(DW), .CW(CW)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .cfg_packet_size  (cfg_packet_size),
    .cfg_pp_group     (cfg_pp_group),
    .cfg_frame_pkts   (cfg_frame_pkts),
    .start            (start),
    .stop             (stop),
    .busy             (busy),
    .cfg_err          (cfg_err),
    .cur_path         (cur_path),
    .frames_out1      (frames_out1),
    .frames_out2      (frames_out2),
    .axis_in_tdata    (axis_in_tdata),
    .axis_in_tvalid   (axis_in_tvalid),
    .axis_in_tready   (axis_in_tready),
    .axis_out1_tdata  (axis_out1_tdata),
    .axis_out1_tvalid (axis_out1_tvalid),
    .axis_out1_tlast  (axis_out1_tlast),
    .axis_out1_tready (axis_out1_tready),
    .axis_out2_tdata  (axis_out2_tdata),
    .axis_out2_tvalid (axis_out2_tvalid),
    .axis_out2_tlast  (axis_out2_tlast),
    .axis_out2_tready (axis_out2_tready)
  );

  task automatic check(input string tag, input logic [DW-1:0] observed,
                       input logic [DW-1:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int idx);
    logic [31:0] w;
    w = 32'hA500_0000 | 32'(idx);
    return {w, ~w, w, 32'h0000_C0DE};
  endfunction

  // Presents beat idx, checks both outputs against the expected routing,
  // then lets one edge pass so it is accepted.
  task automatic do_beat(input int idx, input logic exp_path, input logic exp_last);
    logic [DW-1:0] d;
    d = beat_data(idx);
    axis_in_tdata  = d;
    axis_in_tvalid = 1'b1;
    #2;
    check($sformatf("b%0d in_tready", idx), DW'(axis_in_tready), DW'(1));
    check($sformatf("b%0d cur_path", idx), DW'(cur_path), DW'(exp_path));
    check($sformatf("b%0d o1_valid", idx), DW'(axis_out1_tvalid), DW'(!exp_path));
    check($sformatf("b%0d o1_data", idx), axis_out1_tdata, exp_path ? '0 : d);
    check($sformatf("b%0d o1_last", idx), DW'(axis_out1_tlast), DW'(!exp_path && exp_last));
    check($sformatf("b%0d o2_valid", idx), DW'(axis_out2_tvalid), DW'(exp_path));
    check($sformatf("b%0d o2_data", idx), axis_out2_tdata, exp_path ? d : '0);
    check($sformatf("b%0d o2_last", idx), DW'(axis_out2_tlast), DW'(exp_path && exp_last));
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input int ps, input int pg, input int fp);
    cfg_packet_size = CW'(ps);
    cfg_pp_group    = CW'(pg);
    cfg_frame_pkts  = CW'(fp);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    #2;
    check({tag, " busy"},      DW'(busy), DW'(0));
    check({tag, " in_tready"}, DW'(axis_in_tready), DW'(0));
    check({tag, " o1_valid"},  DW'(axis_out1_tvalid), DW'(0));
    check({tag, " o2_valid"},  DW'(axis_out2_tvalid), DW'(0));
    check({tag, " o1_last"},   DW'(axis_out1_tlast), DW'(0));
    check({tag, " o2_last"},   DW'(axis_out2_tlast), DW'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    resetn = 1'b0;
    cfg_packet_size = '0;
    cfg_pp_group = '0;
    cfg_frame_pkts = '0;
    start = 1'b0;
    stop = 1'b0;
    axis_in_tdata = '0;
    axis_in_tvalid = 1'b1;
    axis_out1_tready = 1'b1;
    axis_out2_tready = 1'b1;

    // ---- Reset state (input valid held high to show it is not accepted)
    repeat (2) @(posedge clk);
    #3;
    check("rst cfg_err",  DW'(cfg_err), DW'(0));
    check("rst cur_path", DW'(cur_path), DW'(0));
    check("rst frames1",  DW'(frames_out1), DW'(0));
    check("rst frames2",  DW'(frames_out2), DW'(0));
    @(posedge clk); #1;
    check_idle("rst");
    resetn = 1'b1;
    axis_in_tvalid = 1'b0;

    // ---- cfg 4/2/2, 40 beats, no backpressure
    pulse_start(4, 2, 2);
    check("run1 busy", DW'(busy), DW'(1));
    for (int i = 0; i < 40; i++) do_beat(i, 1'((i / 8) % 2), (i % 8) == 7);
    axis_in_tvalid = 1'b0;
    check("run1 frames1", DW'(frames_out1), DW'(3));
    check("run1 frames2", DW'(frames_out2), DW'(2));
    pulse_stop();   // on a group boundary: straight to IDLE
    check_idle("run1 stop");

    // ---- Same cfg from reset, out2 stalls for 5 cycles on beat 10
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    pulse_start(4, 2, 2);
    for (int i = 0; i < 10; i++) do_beat(i, 1'((i / 8) % 2), (i % 8) == 7);
    axis_out2_tready = 1'b0;
    axis_in_tdata  = beat_data(10);
    axis_in_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #2;
      check("stall in_tready", DW'(axis_in_tready), DW'(0));
      check("stall o2_valid",  DW'(axis_out2_tvalid), DW'(1));
      check("stall o2_data",   axis_out2_tdata, beat_data(10));
      check("stall o1_valid",  DW'(axis_out1_tvalid), DW'(0));
      check("stall cur_path",  DW'(cur_path), DW'(1));
      check("stall frames1",   DW'(frames_out1), DW'(1));
      @(posedge clk); #1;
    end
    axis_out2_tready = 1'b1;
    for (int i = 10; i < 40; i++) do_beat(i, 1'((i / 8) % 2), (i % 8) == 7);
    axis_in_tvalid = 1'b0;
    check("stall frames1 end", DW'(frames_out1), DW'(3));
    check("stall frames2 end", DW'(frames_out2), DW'(2));
    pulse_stop();
    check_idle("stall stop");

    // ---- Zero config field: rejected, sticky error
    pulse_start(4, 0, 2);
    check("cfgerr flag", DW'(cfg_err), DW'(1));
    axis_in_tvalid = 1'b1;
    check_idle("cfgerr");
    check("cfgerr sticky", DW'(cfg_err), DW'(1));
    axis_in_tvalid = 1'b0;

    // ---- Valid start 1/1/1 clears the error; cfg changes while busy ignored
    pulse_start(1, 1, 1);
    check("pp1 cfg_err", DW'(cfg_err), DW'(0));
    check("pp1 busy", DW'(busy), DW'(1));
    cfg_packet_size = CW'(4);
    cfg_pp_group    = CW'(2);
    cfg_frame_pkts  = CW'(2);
    for (int i = 0; i < 6; i++) begin
      do_beat(100 + i, 1'(i % 2), 1'b1);
      check($sformatf("pp1 b%0d frames1", i), DW'(frames_out1), DW'(3 + (i + 2) / 2));
      check($sformatf("pp1 b%0d frames2", i), DW'(frames_out2), DW'(2 + (i + 1) / 2));
    end
    axis_in_tvalid = 1'b0;
    pulse_stop();
    check_idle("pp1 stop");

    // ---- cfg 2/3/2, stop with beat 3: drain the rest of the group
    pulse_start(2, 3, 2);
    for (int i = 0; i < 3; i++) do_beat(200 + i, 1'b0, 1'b0);
    stop = 1'b1;
    do_beat(203, 1'b0, 1'b1);
    stop = 1'b0;
    check("drain busy", DW'(busy), DW'(1));
    check("drain frames1", DW'(frames_out1), DW'(7));
    do_beat(204, 1'b0, 1'b0);
    do_beat(205, 1'b0, 1'b0);
    axis_in_tvalid = 1'b0;
    check("drain cur_path", DW'(cur_path), DW'(1));
    check_idle("drain end");

    // ---- Restart: back on out1 with per-frame counters cleared
    pulse_start(2, 3, 2);
    check("restart cur_path", DW'(cur_path), DW'(0));
    for (int i = 0; i < 4; i++) do_beat(300 + i, 1'b0, i == 3);
    check("restart frames1", DW'(frames_out1), DW'(8));
    check("restart frames2", DW'(frames_out2), DW'(5));

    // ---- Reset in the middle of a packet
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    pulse_start(4, 2, 2);
    do_beat(400, 1'b0, 1'b0);
    do_beat(401, 1'b0, 1'b0);
    axis_in_tdata = beat_data(402);
    #2;
    check("midrst o1_last", DW'(axis_out1_tlast), DW'(0));
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    #2;
    check("midrst cur_path", DW'(cur_path), DW'(0));
    check("midrst frames1",  DW'(frames_out1), DW'(0));
    check("midrst frames2",  DW'(frames_out2), DW'(0));
    check("midrst cfg_err",  DW'(cfg_err), DW'(0));
    @(posedge clk); #1;
    check_idle("midrst");
    axis_in_tvalid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
